uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 9 +
 rtl/uart_tx_arbiter_rr_pick.sv | 21 ++
 rtl/uart_tx_arbiter.sv | 96 +++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM encoding and default timing shared by the UART TX arbiter files
package uart_tx_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
    localparam int DEF_GAP_CLKS = 16;
    localparam int DEF_TIMEOUT_CLKS = 1 << 20;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: picks the first set request after last_grant, wrapping around
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last_grant,
    output logic         valid,
    output logic [2:0]   index
);
    int best;
    always_comb begin
        valid = |req;
        index = '0;
        best = N;
        for (int j = 0; j < N; j++)
            if (req[j] && (j + N - 1 - int'(last_grant)) % N < best) begin
                best = (j + N - 1 - int'(last_grant)) % N;
                index = 3'(j);
            end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing bytes from NUM_REQ requesters to a single uart_tx
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = DEF_GAP_CLKS,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req_DV,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Lock,
    output logic [NUM_REQ-1:0]     o_Req_Ack,
    output logic [NUM_REQ-1:0]     o_Req_Done,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic [2:0]             o_Grant_Id,
    output logic                   o_Busy,
    output logic                   o_Timeout
);
    localparam int CW = $clog2(max_int(GAP_CLKS, TIMEOUT_CLKS) + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] last_grant, grant_id, pick_idx, next_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [7:0] tx_byte, sel_byte;
    logic pick_valid, lock_hold, lock_dv, lock_sel, done_r, live, tx_done_hit, timeout_hit;
    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req(i_Req_DV),
        .last_grant(last_grant),
        .valid(pick_valid),
        .index(pick_idx)
    );
    always_comb begin
        live = !i_Reset;
        grant_oh = NUM_REQ'(1) << grant_id;
        lock_dv = |(i_Req_DV & (NUM_REQ'(1) << last_grant));
        lock_sel = |(i_Req_Lock & grant_oh);
        next_id = (lock_hold && lock_dv) ? last_grant : pick_idx;
        sel_byte = '0;
        for (int j = 0; j < NUM_REQ; j++)
            if (3'(j) == next_id) sel_byte = i_Req_Byte[8*j +: 8];
        tx_done_hit = state == WAIT_DONE && i_TX_Done;
        timeout_hit = state == WAIT_DONE && !i_TX_Done && cnt == CW'(TIMEOUT_CLKS - 1);
        state_n = state;
        cnt_n = cnt;
        unique case (state)
            IDLE:      if (!i_TX_Active && pick_valid) state_n = LAUNCH;
            LAUNCH:    begin state_n = WAIT_DONE; cnt_n = '0; end
            WAIT_DONE: begin
                cnt_n = cnt + 1'b1;
                if (tx_done_hit || timeout_hit) begin
                    state_n = GAP_CLKS > 0 ? GAP : IDLE;
                    cnt_n = '0;
                end
            end
            GAP: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(GAP_CLKS - 1)) begin state_n = IDLE; cnt_n = '0; end
            end
            default: state_n = IDLE;
        endcase
        // Every output is forced low while reset is held, even before the first reset edge lands
        o_TX_DV = live && state == LAUNCH;
        o_Req_Ack = o_TX_DV ? grant_oh : '0;
        o_Req_Done = (live && done_r) ? grant_oh : '0;
        o_Timeout = live && timeout_hit;
        o_Busy = live && state != IDLE;
        o_TX_Byte = live ? tx_byte : '0;
        o_Grant_Id = live ? grant_id : '0;
    end
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
            cnt <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            grant_id <= '0;
            tx_byte <= '0;
            lock_hold <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            done_r <= tx_done_hit;
            if (state == IDLE && state_n == LAUNCH) begin
                grant_id <= next_id;
                last_grant <= next_id;
                tx_byte <= sel_byte;
            end
            if (tx_done_hit || timeout_hit) lock_hold <= tx_done_hit && lock_sel;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (GAP 16 instance and GAP 0 instance)
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int G = 16;
    localparam int T = 64;
    localparam int K_LAUNCH = 0;
    localparam int K_DONE = 1;
    localparam int K_TIMEOUT = 2;
    typedef struct {
        int inst;
        int kind;
        int id;
        int data;
        int cyc;
    } evt_t;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] dv[2], lock[2], ack[2], done[2];
    logic [8*N-1:0] rb[2];
    logic act[2], txd[2], txdv[2], busy[2], to[2];
    logic [7:0] txb[2];
    logic [2:0] gid[2];
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    evt_t exp_q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(G), .TIMEOUT_CLKS(T)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Req_DV(dv[0]), .i_Req_Byte(rb[0]), .i_Req_Lock(lock[0]),
        .o_Req_Ack(ack[0]), .o_Req_Done(done[0]), .o_TX_DV(txdv[0]), .o_TX_Byte(txb[0]),
        .i_TX_Active(act[0]), .i_TX_Done(txd[0]), .o_Grant_Id(gid[0]), .o_Busy(busy[0]), .o_Timeout(to[0])
    );
    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(0), .TIMEOUT_CLKS(T)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Req_DV(dv[1]), .i_Req_Byte(rb[1]), .i_Req_Lock(lock[1]),
        .o_Req_Ack(ack[1]), .o_Req_Done(done[1]), .o_TX_DV(txdv[1]), .o_TX_Byte(txb[1]),
        .i_TX_Active(act[1]), .i_TX_Done(txd[1]), .o_Grant_Id(gid[1]), .o_Busy(busy[1]), .o_Timeout(to[1])
    );
    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act_v, req_v, cyc);
        end
    endtask
    task automatic expect_evt(input int inst, input int kind, input int id, input int data, input int c);
        exp_q.push_back('{inst, kind, id, data, c});
    endtask
    task automatic observe(input int inst, input int kind);
        evt_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected event: inst %0d kind %0d at cycle %0d, none expected", inst, kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event inst", inst, e.inst);
        chk("event kind", kind, e.kind);
        chk("event cycle", cyc, e.cyc);
        if (kind == K_LAUNCH) begin
            chk("launch tx_dv", txdv[inst], 1);
            chk("launch grant", gid[inst], e.id);
            chk("launch byte", txb[inst], e.data);
            chk("launch ack", ack[inst], 1 << e.id);
        end else if (kind == K_DONE) begin
            chk("done vector", done[inst], 1 << e.id);
        end
    endtask
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (txdv[i] || ack[i] != '0) observe(i, K_LAUNCH);
            if (done[i] != '0) observe(i, K_DONE);
            if (to[i]) observe(i, K_TIMEOUT);
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_tx(input int inst);
        int k = 0;
        while (!txdv[inst] && k < 200) begin
            tick();
            k++;
        end
        if (!txdv[inst]) begin
            checks++;
            failures++;
            $display("FAIL wait_tx: inst %0d gave no strobe within 200 clocks", inst);
        end
    endtask
    // Called in the strobe cycle: line busy for hold clocks, then one TX_Done pulse
    task automatic finish(input int inst, input int id, input int hold, input int nid, input int nbyte, input int gap);
        int d;
        act[inst] = 1'b1;
        tick(hold);
        txd[inst] = 1'b1;
        act[inst] = 1'b0;
        d = cyc;
        expect_evt(inst, K_DONE, id, 0, d + 1);
        if (nid >= 0) expect_evt(inst, K_LAUNCH, nid, nbyte, d + gap + 2);
        tick();
        txd[inst] = 1'b0;
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, busy[0], 0);
        chk({tag, " tx_dv"}, txdv[0], 0);
        chk({tag, " ack"}, ack[0], 0);
        chk({tag, " done"}, done[0], 0);
        chk({tag, " timeout"}, to[0], 0);
        chk({tag, " grant"}, gid[0], 0);
        chk({tag, " byte"}, txb[0], 0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_quiet("in reset");
        tick(2);
        rst = 1'b0;
        chk_quiet("after reset");
    endtask
    initial begin
        int s, c2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dv[i] = '0;
            lock[i] = '0;
            rb[i] = '0;
            act[i] = 1'b0;
            txd[i] = 1'b0;
        end
        tick();
        do_reset();
        // Single request from requester 2
        dv[0] = 4'b0100;
        rb[0][23:16] = 8'hA5;
        expect_evt(0, K_LAUNCH, 2, 8'hA5, cyc + 1);
        wait_tx(0);
        finish(0, 2, 3, -1, 0, G);
        dv[0] = '0;
        tick(G + 4);
        // Full contention from reset: 0,1,2,3,0
        do_reset();
        for (int k = 0; k < N; k++) rb[0][8*k +: 8] = 8'(8'h10 + 8'h11 * k);
        dv[0] = 4'b1111;
        expect_evt(0, K_LAUNCH, 0, 8'h10, cyc + 1);
        wait_tx(0);
        for (int f = 0; f < 5; f++) begin
            if (f < 4) begin
                finish(0, f % 4, 2, (f + 1) % 4, int'(rb[0][8*((f + 1) % 4) +: 8]), G);
                wait_tx(0);
            end else begin
                finish(0, f % 4, 2, -1, 0, G);
                dv[0] = '0;
            end
        end
        tick(G + 4);
        // Lock keeps requester 1 for three frames, then rotation moves to 3
        rb[0][15:8] = 8'h5A;
        rb[0][31:24] = 8'hC3;
        lock[0] = 4'b0010;
        dv[0] = 4'b1010;
        expect_evt(0, K_LAUNCH, 1, 8'h5A, cyc + 1);
        wait_tx(0);
        finish(0, 1, 2, 1, 8'h5A, G);
        wait_tx(0);
        finish(0, 1, 2, 1, 8'h5A, G);
        wait_tx(0);
        lock[0] = '0;
        finish(0, 1, 2, 3, 8'hC3, G);
        wait_tx(0);
        finish(0, 3, 2, -1, 0, G);
        dv[0] = '0;
        tick(G + 4);
        // Watchdog: TX_Done withheld, next request served after the gap
        rb[0][7:0] = 8'h77;
        rb[0][23:16] = 8'h99;
        dv[0] = 4'b0001;
        expect_evt(0, K_LAUNCH, 0, 8'h77, cyc + 1);
        wait_tx(0);
        s = cyc;
        act[0] = 1'b1;
        expect_evt(0, K_TIMEOUT, 0, 0, s + T);
        expect_evt(0, K_LAUNCH, 2, 8'h99, s + T + G + 2);
        tick();
        dv[0] = 4'b0100;
        tick(T - 1);
        act[0] = 1'b0;
        wait_tx(0);
        finish(0, 2, 2, -1, 0, G);
        dv[0] = '0;
        tick(G + 4);
        // Reset mid-frame while the transmitter is still active
        rb[0][15:8] = 8'h3C;
        dv[0] = 4'b0010;
        expect_evt(0, K_LAUNCH, 1, 8'h3C, cyc + 1);
        wait_tx(0);
        act[0] = 1'b1;
        tick(3);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            txd[0] = k == 3;
            tick();
            chk("held off busy", busy[0], 0);
            chk("held off tx_dv", txdv[0], 0);
        end
        txd[0] = 1'b0;
        act[0] = 1'b0;
        c2 = cyc;
        expect_evt(0, K_LAUNCH, 1, 8'h3C, c2 + 1);
        wait_tx(0);
        finish(0, 1, 2, -1, 0, G);
        dv[0] = '0;
        tick(G + 4);
        // Zero gap: back-to-back frames from one requester
        rb[1][7:0] = 8'hE1;
        dv[1] = 4'b0001;
        expect_evt(1, K_LAUNCH, 0, 8'hE1, cyc + 1);
        wait_tx(1);
        finish(1, 0, 2, 0, 8'hE1, 0);
        wait_tx(1);
        finish(1, 0, 2, -1, 0, 0);
        dv[1] = '0;
        tick(20);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
